// File: rtl/qdiv_issue_ctrl_if.sv
// Bundle of operand, result and divider-side signals around the divider front-end controller.
// Signal prefixes are from the controller's point of view; 'master' is the controller itself.
interface qdiv_issue_ctrl_if #(
  parameter int N = 32
);
  logic         i_op_valid;
  logic         o_op_ready;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;

  logic         o_res_valid;
  logic         i_res_ready;
  logic [N-1:0] o_quotient;
  logic         o_overflow;
  logic         o_div_zero;
  logic         o_busy;

  logic [N-1:0] o_div_dividend;
  logic [N-1:0] o_div_divisor;
  logic         o_div_start;
  logic [N-1:0] i_div_quotient;
  logic         i_div_complete;
  logic         i_div_overflow;

  modport master (
    input  i_op_valid, i_dividend, i_divisor, i_res_ready,
           i_div_quotient, i_div_complete, i_div_overflow,
    output o_op_ready, o_res_valid, o_quotient, o_overflow, o_div_zero, o_busy,
           o_div_dividend, o_div_divisor, o_div_start
  );

  modport slave (
    output i_op_valid, i_dividend, i_divisor, i_res_ready,
           i_div_quotient, i_div_complete, i_div_overflow,
    input  o_op_ready, o_res_valid, o_quotient, o_overflow, o_div_zero, o_busy,
           o_div_dividend, o_div_divisor, o_div_start
  );
endinterface

// File: rtl/qdiv_issue_ctrl.sv
// Front-end for the sign-magnitude serial divider: two's-complement <-> sign-magnitude
// conversion, divide-by-zero interception, start/complete handshake and result saturation.
module qdiv_issue_ctrl #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  qdiv_issue_ctrl_if.master  bus
);

  if (Q < 1 || Q > N - 2) begin : g_bad_q
    $error("qdiv_issue_ctrl: Q must lie in 1..N-2");
  end

  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MAX_NEG = ~MAX_POS + 1'b1;
  localparam logic [N-1:0] MIN_TWO = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         w_div_start;

  logic [N-1:0] r_div_dividend;
  logic [N-1:0] r_div_divisor;
  logic [N-1:0] r_quotient;
  logic         r_overflow;
  logic         r_div_zero;

  logic [N-1:0] w_res_twos;
  logic [N-1:0] w_res_sat;
  logic [N-1:0] w_dz_quot;

  // The most negative input has no sign-magnitude image, so it clamps to the largest magnitude.
  function automatic logic [N-1:0] to_sign_mag(input logic [N-1:0] x);
    logic [N-1:0] mag;
    mag = x[N-1] ? (~x + 1'b1) : x;
    if (x == MIN_TWO) return {1'b1, {(N-1){1'b1}}};
    return {x[N-1], mag[N-2:0]};
  endfunction

  function automatic logic [N-1:0] from_sign_mag(input logic [N-1:0] sm);
    logic [N-1:0] mag;
    mag = {1'b0, sm[N-2:0]};
    if (mag == '0) return '0;
    return sm[N-1] ? (~mag + 1'b1) : mag;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_div_start  = 1'b0;
    case (r_state)
      S_IDLE:
        if (bus.i_op_valid)
          w_state_next = (bus.i_divisor == '0) ? S_RESULT : S_ISSUE;
      S_ISSUE:
        if (bus.i_div_complete) begin
          w_div_start  = 1'b1;
          w_state_next = S_WAIT_ACK;
        end
      S_WAIT_ACK:
        if (!bus.i_div_complete) w_state_next = S_WAIT_DONE;
      S_WAIT_DONE:
        if (bus.i_div_complete) w_state_next = S_RESULT;
      S_RESULT:
        if (bus.i_res_ready) w_state_next = S_IDLE;
      default:
        w_state_next = S_IDLE;
    endcase
  end

  assign w_res_twos = from_sign_mag(bus.i_div_quotient);
  // Saturation direction comes from the operand signs, independent of the divider's overflow output.
  assign w_res_sat  = (r_div_dividend[N-1] ^ r_div_divisor[N-1]) ? MAX_NEG : MAX_POS;
  assign w_dz_quot  = (bus.i_dividend == '0) ? '0 :
                      (bus.i_dividend[N-1] ? MAX_NEG : MAX_POS);

  // NOTE: all datapath registers are reset, since they drive module outputs with defined reset values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_quotient     <= '0;
      r_overflow     <= 1'b0;
      r_div_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (bus.i_op_valid) begin
            r_div_dividend <= to_sign_mag(bus.i_dividend);
            r_div_divisor  <= to_sign_mag(bus.i_divisor);
            if (bus.i_divisor == '0) begin
              r_quotient <= w_dz_quot;
              r_div_zero <= 1'b1;
              r_overflow <= 1'b0;
            end
          end
        S_WAIT_DONE:
          if (bus.i_div_complete) begin
            r_quotient <= bus.i_div_overflow ? w_res_sat : w_res_twos;
            r_overflow <= bus.i_div_overflow;
            r_div_zero <= 1'b0;
          end
        S_RESULT:
          if (bus.i_res_ready) begin
            r_overflow <= 1'b0;
            r_div_zero <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign bus.o_op_ready     = (r_state == S_IDLE) && !i_rst;
  assign bus.o_res_valid    = (r_state == S_RESULT);
  assign bus.o_busy         = (r_state != S_IDLE);
  assign bus.o_quotient     = r_quotient;
  assign bus.o_overflow     = r_overflow;
  assign bus.o_div_zero     = r_div_zero;
  assign bus.o_div_dividend = r_div_dividend;
  assign bus.o_div_divisor  = r_div_divisor;
  assign bus.o_div_start    = w_div_start;

endmodule

// File: tb/tb_qdiv_issue_ctrl.sv
// Directed bench for qdiv_issue_ctrl with a behavioural stand-in for the serial divider.
module tb_qdiv_issue_ctrl;
  localparam int N = 32;
  localparam int Q = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qdiv_issue_ctrl_if #(.N(N)) bus ();

  qdiv_issue_ctrl #(.Q(Q), .N(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Divider stand-in: no reset, complete low while busy for m_lat cycles.
  logic         m_done = 1'b1;
  logic [N-1:0] m_quot = '0;
  logic         m_ovf  = 1'b0;
  logic [N-1:0] m_dd   = '0;
  logic [N-1:0] m_dv   = '0;
  int           m_cnt  = 0;
  int           m_lat  = 34;
  int           n_starts = 0;
  int           n_bad_starts = 0;

  assign bus.i_div_complete = m_done;
  assign bus.i_div_quotient = m_quot;
  assign bus.i_div_overflow = m_ovf;

  function automatic logic [N:0] divide(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned ua, ub, q;
    ua = 64'(a[N-2:0]);
    ub = 64'(b[N-2:0]);
    q  = (ua << Q) / ub;
    return {(q > 64'h7FFF_FFFF), a[N-1] ^ b[N-1], q[N-2:0]};
  endfunction

  always @(posedge clk) begin
    if (bus.o_div_start) begin
      n_starts <= n_starts + 1;
      if (!m_done) n_bad_starts <= n_bad_starts + 1;
    end
    if (bus.o_div_start && m_done) begin
      m_done <= 1'b0;
      m_cnt  <= m_lat;
      m_dd   <= bus.o_div_dividend;
      m_dv   <= bus.o_div_divisor;
    end else if (!m_done) begin
      if (m_cnt <= 1) begin
        m_done          <= 1'b1;
        {m_ovf, m_quot} <= divide(m_dd, m_dv);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic run_op(input string tag, input logic [N-1:0] dd, input logic [N-1:0] dv,
                        input logic [N-1:0] exp_dd, input logic [N-1:0] exp_q,
                        input logic exp_ovf, input logic exp_dz);
    int s0;
    int waited;
    @(negedge clk);
    check({tag, "_op_ready"}, N'(bus.o_op_ready), 1);
    bus.i_op_valid = 1'b1;
    bus.i_dividend = dd;
    bus.i_divisor  = dv;
    s0 = n_starts;
    @(negedge clk);
    bus.i_op_valid = 1'b0;
    if (exp_dz) check({tag, "_dz_latency"}, N'(bus.o_res_valid), 1);
    else        check({tag, "_sm_dividend"}, bus.o_div_dividend, exp_dd);
    waited = 0;
    while (!bus.o_res_valid && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_res_valid"}, N'(bus.o_res_valid), 1);
    check({tag, "_quotient"}, bus.o_quotient, exp_q);
    check({tag, "_flags"}, N'({bus.o_overflow, bus.o_div_zero}), N'({exp_ovf, exp_dz}));
    check({tag, "_starts"}, N'(n_starts - s0), exp_dz ? 0 : 1);
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    check({tag, "_after_hs"}, N'({bus.o_res_valid, bus.o_overflow, bus.o_div_zero, bus.o_busy}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0;
    int waited;
    int bp_bad;
    bus.i_op_valid  = 1'b0;
    bus.i_dividend  = '0;
    bus.i_divisor   = '0;
    bus.i_res_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_op_ready", N'(bus.o_op_ready), 0);
    check("rst_outputs", N'({bus.o_res_valid, bus.o_overflow, bus.o_div_zero,
                              bus.o_div_start, bus.o_busy}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_op_ready", N'(bus.o_op_ready), 1);
    check("idle_quotient", bus.o_quotient, 0);
    check("idle_div_dividend", bus.o_div_dividend, 0);
    check("idle_div_divisor", bus.o_div_divisor, 0);

    run_op("pos_6_2",  32'h0003_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_8000, 1'b0, 1'b0);
    run_op("neg_6_2",  32'hFFFD_0000, 32'h0001_0000, 32'h8003_0000, 32'hFFFE_8000, 1'b0, 1'b0);
    run_op("dz_pos",   32'h0000_8000, 32'h0000_0000, 32'h0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("dz_neg",   32'hFFFF_8000, 32'h0000_0000, 32'h0, 32'h8000_0001, 1'b0, 1'b1);
    run_op("dz_zero",  32'h0000_0000, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b1);
    run_op("ovf_pos",  32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_op("ovf_neg",  32'h7FFF_0000, 32'hFFFF_FFFF, 32'h7FFF_0000, 32'h8000_0001, 1'b1, 1'b0);
    run_op("min_in",   32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'hC000_0001, 1'b0, 1'b0);
    run_op("neg_zero", 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

    // Backpressure: -6.0 / -2.0 = 3.0, result held while downstream stalls.
    @(negedge clk);
    bus.i_op_valid = 1'b1;
    bus.i_dividend = 32'hFFFD_0000;
    bus.i_divisor  = 32'hFFFF_0000;
    s0 = n_starts;
    @(negedge clk);
    bus.i_op_valid = 1'b0;
    check("bp_sm_divisor", bus.o_div_divisor, 32'h8001_0000);
    waited = 0;
    while (!bus.o_res_valid && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("bp_res_valid", N'(bus.o_res_valid), 1);
    bp_bad = 0;
    bus.i_op_valid = 1'b1;
    bus.i_dividend = 32'h0000_1000;
    bus.i_divisor  = 32'h0000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_quotient !== 32'h0001_8000 || bus.o_overflow !== 1'b0 ||
          bus.o_div_zero !== 1'b0 || bus.o_op_ready !== 1'b0 || bus.o_res_valid !== 1'b1)
        bp_bad++;
    end
    bus.i_op_valid = 1'b0;
    check("bp_stable_cycles", N'(bp_bad), 0);
    check("bp_quotient", bus.o_quotient, 32'h0001_8000);
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    check("bp_after_hs", N'({bus.o_res_valid, bus.o_busy, bus.o_div_zero}), 0);
    check("bp_op_ready", N'(bus.o_op_ready), 1);
    check("bp_starts", N'(n_starts - s0), 1);

    // Reset while the divider is running, then a new op that must wait for it.
    @(negedge clk);
    bus.i_op_valid = 1'b1;
    bus.i_dividend = 32'h0003_0000;
    bus.i_divisor  = 32'h0001_0000;
    @(negedge clk);
    bus.i_op_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", N'(bus.o_busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", N'({bus.o_op_ready, bus.o_res_valid, bus.o_busy, bus.o_div_start,
                              bus.o_overflow, bus.o_div_zero}), 0);
    check("mid_rst_quotient", bus.o_quotient, 0);
    check("mid_rst_div_dividend", bus.o_div_dividend, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'h0005_0000, 32'h0002_0000, 32'h0005_0000, 32'h0001_4000, 1'b0, 1'b0);

    check("start_while_busy", N'(n_bad_starts), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
